// File: rtl/sc_schedule_controller_if.sv
// Schedule interface between the SC decoder sequencer and its consumers
// (partial-sums distributor, PE array and LLR-memory control).
//
// Parameters
//   n  log2 code length N
//   p  log2 PE count P
//
// Signals
//   en            start request
//   hold          stall from LLR memory
//   decoder_busy  codeword in progress
//   bit_index     current decoded bit i
//   stage_index   current stage s (n-1 = channel side, 0 = decision side)
//   exe_index     execution slice within stage s
//   fg_sel        0 = f function, 1 = g function
//   pe_valid      step on the outputs is valid this cycle
//   done          one-cycle pulse when the codeword is finished
//
// Modports
//   master  the sequencer: takes en/hold, drives the schedule
//   slave   the consumer side
interface sc_schedule_controller_if #(
    parameter int n = 3,
    parameter int p = 1
) ();
    localparam int SW = $clog2(n);
    localparam int EW = n - p;

    logic          en;
    logic          hold;
    logic          decoder_busy;
    logic [n-1:0]  bit_index;
    logic [SW-1:0] stage_index;
    logic [EW-1:0] exe_index;
    logic          fg_sel;
    logic          pe_valid;
    logic          done;

    modport master (
        input  en, hold,
        output decoder_busy, bit_index, stage_index, exe_index, fg_sel, pe_valid, done
    );

    modport slave (
        output en, hold,
        input  decoder_busy, bit_index, stage_index, exe_index, fg_sel, pe_valid, done
    );
endinterface

// File: rtl/sc_schedule_controller.sv
// Sequencer of the semi-parallel SC decoder. Walks a codeword through bits
// 0..N-1 and, for every bit, issues the stage/execution steps for the 2**p
// PE array. All outputs are registered.
//
// Ports
//   clk    clock, rising edge
//   rst_n  asynchronous active-low reset
//   sif    schedule interface (master modport): en/hold in, schedule out
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for en; schedule parked at (0, n-1, 0)
// RUN   | one step per cycle while hold is low; hold freezes the step
// DONE  | one-cycle done pulse, then back to IDLE
module sc_schedule_controller #(
    parameter int n = 3,
    parameter int p = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    sc_schedule_controller_if.master sif
);
    localparam int SW = $clog2(n);
    localparam int EW = n - p;

    localparam logic [SW-1:0] STAGE_TOP = SW'(n - 1);
    localparam logic [n-1:0]  BIT_LAST  = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [n-1:0]  bit_q, bit_d;
    logic [SW-1:0] stage_q, stage_d;
    logic [EW-1:0] exe_q, exe_d;
    logic          busy_q, busy_d;
    logic          fg_q, fg_d;
    logic          valid_q, valid_d;
    logic          done_q, done_d;

    // Start stage of a new bit: trailing-zero count of its index.
    function automatic logic [SW-1:0] ctz(input logic [n-1:0] v);
        logic [SW-1:0] r;
        r = '0;
        for (int i = n - 1; i >= 0; i--) begin
            if (v[i]) r = SW'(i);
        end
        return r;
    endfunction

    // Last execution slice of stage s: E(s)-1.
    function automatic logic [EW-1:0] exe_last(input logic [SW-1:0] s);
        if (int'(s) >= p) return EW'((1 << (int'(s) - p)) - 1);
        return '0;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            bit_q   <= '0;
            stage_q <= STAGE_TOP;
            exe_q   <= '0;
            busy_q  <= 1'b0;
            fg_q    <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            stage_q <= stage_d;
            exe_q   <= exe_d;
            busy_q  <= busy_d;
            fg_q    <= fg_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        stage_d = stage_q;
        exe_d   = exe_q;
        busy_d  = busy_q;
        valid_d = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (sif.en) begin
                    state_d = ST_RUN;
                    bit_d   = '0;
                    stage_d = STAGE_TOP;
                    exe_d   = '0;
                    busy_d  = 1'b1;
                    valid_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (sif.hold) begin
                    valid_d = 1'b0;
                end else if (!valid_q) begin
                    // Coming out of a stall: reissue the frozen step unchanged.
                    valid_d = 1'b1;
                end else if (exe_q != exe_last(stage_q)) begin
                    exe_d   = exe_q + 1'b1;
                    valid_d = 1'b1;
                end else if (stage_q != '0) begin
                    stage_d = stage_q - 1'b1;
                    exe_d   = '0;
                    valid_d = 1'b1;
                end else if (bit_q == BIT_LAST) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    bit_d   = bit_q + 1'b1;
                    stage_d = ctz(bit_q + 1'b1);
                    exe_d   = '0;
                    valid_d = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                bit_d   = '0;
                stage_d = STAGE_TOP;
                exe_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        fg_d = bit_d[stage_d];
    end

    assign sif.decoder_busy = busy_q;
    assign sif.bit_index    = bit_q;
    assign sif.stage_index  = stage_q;
    assign sif.exe_index    = exe_q;
    assign sif.fg_sel       = fg_q;
    assign sif.pe_valid     = valid_q;
    assign sif.done         = done_q;
endmodule

// File: tb/tb_sc_schedule_controller.sv
module tb_sc_schedule_controller;
    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    sc_schedule_controller_if #(.n(3), .p(1)) a_if ();
    sc_schedule_controller_if #(.n(4), .p(0)) b_if ();

    sc_schedule_controller #(.n(3), .p(1)) dut_a (.clk(clk), .rst_n(rst_n), .sif(a_if));
    sc_schedule_controller #(.n(4), .p(0)) dut_b (.clk(clk), .rst_n(rst_n), .sif(b_if));

    // Hand-written n=3, p=1 schedule (bit, stage, exe, fg).
    int exp_bit[16] = '{0, 0, 0, 0, 1, 2, 2, 3, 4, 4, 4, 4, 5, 6, 6, 7};
    int exp_stg[16] = '{2, 2, 1, 0, 0, 1, 0, 0, 2, 2, 1, 0, 0, 1, 0, 0};
    int exp_exe[16] = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    int exp_fg[16]  = '{0, 0, 0, 0, 1, 1, 0, 1, 1, 1, 0, 0, 1, 1, 0, 1};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Step packed as 0xBSE: bit, stage, exe nibbles.
    task automatic chk_a_step(input string tag, input int k, input logic pv);
        logic [31:0] obs;
        obs = (32'(a_if.bit_index) << 8) | (32'(a_if.stage_index) << 4) | 32'(a_if.exe_index);
        chk({tag, "_bse"}, obs, 32'((exp_bit[k] << 8) | (exp_stg[k] << 4) | exp_exe[k]));
        chk({tag, "_fg"}, 32'(a_if.fg_sel), 32'(exp_fg[k]));
        chk({tag, "_pv"}, 32'(a_if.pe_valid), 32'(pv));
        chk({tag, "_busy"}, 32'(a_if.decoder_busy), 32'd1);
        chk({tag, "_done"}, 32'(a_if.done), 32'd0);
    endtask

    task automatic start_a();
        @(negedge clk);
        a_if.en = 1'b1;
        @(negedge clk);
        a_if.en = 1'b0;
    endtask

    // Entered at the negedge where step 0 is visible.
    task automatic run_seq(input string tag, input int hold_at, input int hold_len, input int stop_at);
        for (int k = 0; k < 16; k++) begin
            if (k > 0) @(negedge clk);
            chk_a_step($sformatf("%s_s%0d", tag, k), k, 1'b1);
            if (k == stop_at) return;
            if (k == hold_at) begin
                a_if.hold = 1'b1;
                for (int h = 0; h < hold_len; h++) begin
                    @(negedge clk);
                    chk_a_step($sformatf("%s_hold%0d", tag, h), k, 1'b0);
                    if (h == hold_len - 1) a_if.hold = 1'b0;
                end
                @(negedge clk);
                chk_a_step($sformatf("%s_reissue", tag), k, 1'b1);
            end
        end
        @(negedge clk);
        chk({tag, "_done_pulse"}, 32'(a_if.done), 32'd1);
        chk({tag, "_done_busy"}, 32'(a_if.decoder_busy), 32'd0);
        chk({tag, "_done_pv"}, 32'(a_if.pe_valid), 32'd0);
        @(negedge clk);
        chk({tag, "_idle_done"}, 32'(a_if.done), 32'd0);
        chk({tag, "_idle_busy"}, 32'(a_if.decoder_busy), 32'd0);
        chk({tag, "_idle_pv"}, 32'(a_if.pe_valid), 32'd0);
    endtask

    task automatic chk_a_reset(input string tag);
        chk({tag, "_busy"}, 32'(a_if.decoder_busy), 32'd0);
        chk({tag, "_bit"}, 32'(a_if.bit_index), 32'd0);
        chk({tag, "_stage"}, 32'(a_if.stage_index), 32'd2);
        chk({tag, "_exe"}, 32'(a_if.exe_index), 32'd0);
        chk({tag, "_fg"}, 32'(a_if.fg_sel), 32'd0);
        chk({tag, "_pv"}, 32'(a_if.pe_valid), 32'd0);
        chk({tag, "_done"}, 32'(a_if.done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt;
        int exp_cycles;
        bit first;

        a_if.en = 1'b0; a_if.hold = 1'b0;
        b_if.en = 1'b0; b_if.hold = 1'b0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;

        // Reset state
        @(negedge clk);
        chk_a_reset("rst_a");
        chk("rst_b_stage", 32'(b_if.stage_index), 32'd3);
        chk("rst_b_busy", 32'(b_if.decoder_busy), 32'd0);
        rst_n = 1'b1;

        // T1/T2: plain codeword
        start_a();
        run_seq("t1", -1, 0, -1);

        // T3: 3-cycle hold on step (4,2,1)
        start_a();
        run_seq("t3", 9, 3, -1);

        // T4: en held high through the whole run and DONE, then a restart
        @(negedge clk);
        a_if.en = 1'b1;
        @(negedge clk);
        run_seq("t4a", -1, 0, -1);
        @(negedge clk);
        a_if.en = 1'b0;
        run_seq("t4b", -1, 0, -1);

        // T5: reset at step (5,0,0)
        start_a();
        run_seq("t5a", -1, 0, 12);
        rst_n = 1'b0;
        #1;
        chk_a_reset("t5_async");
        @(negedge clk);
        chk_a_reset("t5_held");
        rst_n = 1'b1;
        start_a();
        run_seq("t5b", -1, 0, -1);

        // T6: n=4, p=0
        @(negedge clk);
        b_if.en = 1'b1;
        @(negedge clk);
        b_if.en = 1'b0;
        first = 1'b1;
        for (int s = 3; s >= 0; s--) begin
            for (int e = 0; e < (1 << s); e++) begin
                if (!first) @(negedge clk);
                first = 1'b0;
                chk($sformatf("t6_b0_s%0d_e%0d", s, e),
                    (32'(b_if.bit_index) << 8) | (32'(b_if.stage_index) << 4) | 32'(b_if.exe_index),
                    32'((s << 4) | e));
                chk($sformatf("t6_b0_s%0d_e%0d_pv", s, e), 32'(b_if.pe_valid), 32'd1);
            end
        end
        // Expected RUN cycles: bit 0 starts at stage 3, others at ctz(i); stage s has 2**s steps.
        exp_cycles = 15;
        for (int i = 1; i < 16; i++) begin
            int tz;
            tz = 0;
            while (((i >> tz) & 1) == 0) tz++;
            exp_cycles += (1 << (tz + 1)) - 1;
        end
        cnt = 15;
        for (int g = 0; g < 200; g++) begin
            @(negedge clk);
            if (b_if.done) break;
            cnt++;
        end
        chk("t6_done_seen", 32'(b_if.done), 32'd1);
        chk("t6_run_cycles", 32'(cnt), 32'(exp_cycles));
        @(negedge clk);
        chk("t6_idle_busy", 32'(b_if.decoder_busy), 32'd0);
        chk("t6_idle_stage", 32'(b_if.stage_index), 32'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
